// File: rtl/lenet_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lenet_pkg
// Description : Shared defaults for the LeNet front-end blocks and the
//               helper that locates one window element inside a flattened
//               K x K x CH window vector.
// Revision    : 1.0 - initial release
// ============================================================================
package lenet_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int CH_DEF     = 1;
    localparam int IMG_W_DEF  = 32;
    localparam int IMG_H_DEF  = 32;
    localparam int K_DEF      = 5;

    // Bit offset of element (r, c, ch) in a window: row-major over (r, c),
    // channels packed inside each pixel with channel 0 in the LSBs.
    function automatic int win_offset(input int r, input int c, input int ch,
                                      input int k, input int chn, input int dw);
        return ((r * k + c) * chn + ch) * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_window_gen_line_delay.sv
`default_nettype none
// ============================================================================
// Module      : line_delay
// Description : Enable-gated shift line, DEPTH entries of WIDTH bits. The
//               output is the entry shifted in DEPTH enables ago, so with
//               DEPTH equal to the line width it yields the pixel one line up.
// Revision    : 1.0 - initial release
// ============================================================================
module line_delay #(
    parameter int DEPTH = 32,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Shift the whole line by one entry on every enabled cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (en) begin
            r_mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    assign dout = r_mem[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/line_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : line_window_gen
// Description : Sliding K x K x CH window generator for raster pixel
//               streams. Buffers K-1 lines, keeps a K x K window register
//               and emits every fully-populated window with its top-left
//               coordinate through a valid/ready output stage.
// Revision    : 1.0 - initial release
// ============================================================================
module line_window_gen
    import lenet_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CH     = CH_DEF,
    parameter int IMG_W  = IMG_W_DEF,
    parameter int IMG_H  = IMG_H_DEF,
    parameter int K      = K_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_sof,
    input  logic [CH*DATA_W-1:0]         in_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [K*K*CH*DATA_W-1:0]     out_data,
    output logic [$clog2(IMG_W)-1:0]     out_x,
    output logic [$clog2(IMG_H)-1:0]     out_y,
    output logic                         out_last
);

    localparam int PIX_W = CH * DATA_W;
    localparam int WIN_W = K * K * PIX_W;
    localparam int XW    = $clog2(IMG_W);
    localparam int YW    = $clog2(IMG_H);

    localparam logic [XW-1:0] c_x_last = XW'(IMG_W - 1);
    localparam logic [YW-1:0] c_y_last = YW'(IMG_H - 1);
    localparam logic [XW-1:0] c_x_win  = XW'(K - 1);
    localparam logic [YW-1:0] c_y_win  = YW'(K - 1);

    // r_x / r_y hold the position the next accepted pixel will occupy.
    logic [XW-1:0]    r_x;
    logic [YW-1:0]    r_y;
    logic [XW-1:0]    w_px;
    logic [YW-1:0]    w_py;
    logic [XW-1:0]    w_nx;
    logic [YW-1:0]    w_ny;
    logic             w_accept;
    logic             w_emit;
    logic             w_is_last;
    logic [WIN_W-1:0] r_win;
    logic [WIN_W-1:0] w_win_next;
    logic [PIX_W-1:0] w_tap [K];

    assign in_ready = !rst && (!out_valid || out_ready);
    assign w_accept = in_valid && in_ready;

    // Position of the pixel being offered and the position after it.
    always_comb begin
        w_px = in_sof ? '0 : r_x;
        w_py = in_sof ? '0 : r_y;
        w_nx = w_px + XW'(1);
        w_ny = w_py;
        if (w_px == c_x_last) begin
            w_nx = '0;
            w_ny = (w_py == c_y_last) ? '0 : w_py + YW'(1);
        end
    end

    assign w_emit    = w_accept && (w_px >= c_x_win) && (w_py >= c_y_win);
    assign w_is_last = (w_px == c_x_last) && (w_py == c_y_last);

    // Advance the raster position on every accepted pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_x <= '0;
            r_y <= '0;
        end else if (w_accept) begin
            r_x <= w_nx;
            r_y <= w_ny;
        end
    end

    // Tap 0 is the incoming pixel; tap j is the pixel j lines above it.
    assign w_tap[0] = in_data;

    for (genvar j = 1; j < K; j++) begin : g_line
        line_delay #(
            .DEPTH (IMG_W),
            .WIDTH (PIX_W)
        ) u_line_delay (
            .clk  (clk),
            .rst  (rst),
            .en   (w_accept),
            .din  (w_tap[j-1]),
            .dout (w_tap[j])
        );
    end

    // Next window: every column moves one step left, the rightmost column
    // is refilled from the taps with the newest line at the bottom row.
    for (genvar r = 0; r < K; r++) begin : g_row
        for (genvar c = 0; c < K; c++) begin : g_col
            localparam int OFF = win_offset(r, c, 0, K, CH, DATA_W);
            if (c < K - 1) begin : g_shift
                localparam int SRC = win_offset(r, c + 1, 0, K, CH, DATA_W);
                assign w_win_next[OFF +: PIX_W] = r_win[SRC +: PIX_W];
            end else begin : g_fill
                assign w_win_next[OFF +: PIX_W] = w_tap[K-1-r];
            end
        end
    end

    // Window register follows the stream only on accepted pixels.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_win <= '0;
        end else if (w_accept) begin
            r_win <= w_win_next;
        end
    end

    // Output stage: load on emit, otherwise drop valid once consumed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_x     <= '0;
            out_y     <= '0;
            out_last  <= 1'b0;
        end else if (w_emit) begin
            out_valid <= 1'b1;
            out_data  <= w_win_next;
            out_x     <= w_px - c_x_win;
            out_y     <= w_py - c_y_win;
            out_last  <= w_is_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_line_window_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_window_gen
// Description : Self-checking bench. DUT A is the LeNet conv1 configuration
//               (32x32, K=5, CH=1); DUT B is a small two-channel 8x8, K=3
//               instance. Each DUT is followed by a cycle model built on a
//               plain image array.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_window_gen;

    localparam int A_W = 32, A_H = 32, A_K = 5, A_WIN = A_K * A_K * 8;
    localparam int B_W = 8, B_H = 8, B_K = 3, B_WIN = B_K * B_K * 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- DUT A ----------------
    logic             a_in_valid, a_in_ready, a_in_sof;
    logic [7:0]       a_in_data;
    logic             a_out_valid, a_out_ready, a_out_last;
    logic [A_WIN-1:0] a_out_data;
    logic [4:0]       a_out_x, a_out_y;

    line_window_gen #(.DATA_W(8), .CH(1), .IMG_W(A_W), .IMG_H(A_H), .K(A_K)) u_dut_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_sof(a_in_sof), .in_data(a_in_data), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_x(a_out_x),
        .out_y(a_out_y), .out_last(a_out_last));

    // ---------------- DUT B ----------------
    logic             b_in_valid, b_in_ready, b_in_sof;
    logic [15:0]      b_in_data;
    logic             b_out_valid, b_out_ready, b_out_last;
    logic [B_WIN-1:0] b_out_data;
    logic [2:0]       b_out_x, b_out_y;

    line_window_gen #(.DATA_W(8), .CH(2), .IMG_W(B_W), .IMG_H(B_H), .K(B_K)) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_sof(b_in_sof), .in_data(b_in_data), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_x(b_out_x),
        .out_y(b_out_y), .out_last(b_out_last));

    // ---------------- reference model A ----------------
    logic [7:0]        a_img [A_H][A_W];
    logic              a_mv;
    logic [A_WIN-1:0]  a_md;
    int                a_mx, a_my, a_nx, a_ny;
    logic              a_ml;
    int                a_got, a_lastcnt, a_acc, a_first_acc, a_first_x, a_first_y;
    logic [A_WIN+9:0]  a_rec [$];
    logic [A_WIN+9:0]  ref_seq [$];

    always @(negedge clk) begin : mon_a
        int px, py;
        logic acc, er;
        if (rst) begin
            a_mv = 1'b0; a_md = '0; a_nx = 0; a_ny = 0;
        end else begin
            er = !a_mv || a_out_ready;
            checks++;
            if (a_in_ready !== er) begin
                failures++;
                $display("FAIL a_in_ready got=%b exp=%b t=%0t", a_in_ready, er, $time);
            end
            checks++;
            if (a_out_valid !== a_mv) begin
                failures++;
                $display("FAIL a_out_valid got=%b exp=%b t=%0t", a_out_valid, a_mv, $time);
            end
            if (a_mv) begin
                checks++;
                if (a_out_data !== a_md || a_out_x !== 5'(a_mx) || a_out_y !== 5'(a_my) || a_out_last !== a_ml) begin
                    failures++;
                    $display("FAIL a_window got x=%0d y=%0d last=%b exp x=%0d y=%0d last=%b data_eq=%b t=%0t",
                             a_out_x, a_out_y, a_out_last, a_mx, a_my, a_ml, a_out_data === a_md, $time);
                end
            end
            if (a_out_valid === 1'b1) begin
                if (a_first_acc < 0 && a_acc > 0) begin
                    a_first_acc = a_acc; a_first_x = int'(a_out_x); a_first_y = int'(a_out_y);
                end
                if (a_out_ready) begin
                    a_got++;
                    a_rec.push_back({a_out_y, a_out_x, a_out_data});
                    if (a_out_last) a_lastcnt++;
                end
            end
            acc = a_in_valid && er;
            if (acc) begin
                a_acc++;
                px = a_in_sof ? 0 : a_nx;
                py = a_in_sof ? 0 : a_ny;
                a_img[py][px] = a_in_data;
                a_nx = px + 1; a_ny = py;
                if (a_nx == A_W) begin
                    a_nx = 0; a_ny = py + 1;
                    if (a_ny == A_H) a_ny = 0;
                end
                if (px >= A_K - 1 && py >= A_K - 1) begin
                    a_mv = 1'b1; a_mx = px - (A_K - 1); a_my = py - (A_K - 1);
                    a_ml = (px == A_W - 1) && (py == A_H - 1);
                    for (int r = 0; r < A_K; r++)
                        for (int c = 0; c < A_K; c++)
                            a_md[(r * A_K + c) * 8 +: 8] = a_img[a_my + r][a_mx + c];
                end else if (a_out_ready) a_mv = 1'b0;
            end else if (a_out_ready) a_mv = 1'b0;
        end
    end

    // ---------------- reference model B ----------------
    logic [15:0]       b_img [B_H][B_W];
    logic              b_mv;
    logic [B_WIN-1:0]  b_md;
    int                b_mx, b_my, b_nx, b_ny, b_got;
    logic              b_ml;
    int                b_lastpos [$];
    logic [B_WIN-1:0]  b_rec [$];

    always @(negedge clk) begin : mon_b
        int px, py;
        logic er;
        if (rst) begin
            b_mv = 1'b0; b_nx = 0; b_ny = 0;
        end else begin
            er = !b_mv || b_out_ready;
            checks++;
            if (b_out_valid !== b_mv || b_in_ready !== er) begin
                failures++;
                $display("FAIL b_handshake got v=%b r=%b exp v=%b r=%b", b_out_valid, b_in_ready, b_mv, er);
            end
            if (b_mv) begin
                checks++;
                if (b_out_data !== b_md || b_out_x !== 3'(b_mx) || b_out_y !== 3'(b_my) || b_out_last !== b_ml) begin
                    failures++;
                    $display("FAIL b_window got x=%0d y=%0d last=%b exp x=%0d y=%0d last=%b data_eq=%b",
                             b_out_x, b_out_y, b_out_last, b_mx, b_my, b_ml, b_out_data === b_md);
                end
            end
            if (b_out_valid === 1'b1 && b_out_ready) begin
                b_got++;
                b_rec.push_back(b_out_data);
                if (b_out_last) b_lastpos.push_back(b_got);
            end
            if (b_in_valid && er) begin
                px = b_in_sof ? 0 : b_nx;
                py = b_in_sof ? 0 : b_ny;
                b_img[py][px] = b_in_data;
                b_nx = px + 1; b_ny = py;
                if (b_nx == B_W) begin
                    b_nx = 0; b_ny = py + 1;
                    if (b_ny == B_H) b_ny = 0;
                end
                if (px >= B_K - 1 && py >= B_K - 1) begin
                    b_mv = 1'b1; b_mx = px - (B_K - 1); b_my = py - (B_K - 1);
                    b_ml = (px == B_W - 1) && (py == B_H - 1);
                    for (int r = 0; r < B_K; r++)
                        for (int c = 0; c < B_K; c++)
                            b_md[(r * B_K + c) * 16 +: 16] = b_img[b_my + r][b_mx + c];
                end else if (b_out_ready) b_mv = 1'b0;
            end else if (b_out_ready) b_mv = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    int d_x, d_y;

    task automatic a_reset_stats();
        a_got = 0; a_lastcnt = 0; a_acc = 0; a_first_acc = -1;
        a_first_x = -1; a_first_y = -1;
        a_rec.delete();
    endtask

    task automatic drive_a(input int n, input bit sof_first, input bit ramp, input int gap_pct);
        for (int i = 0; i < n; i++) begin
            int px, py, t;
            bit got, sof;
            while (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                a_in_valid = 1'b0;
                @(posedge clk); #2;
            end
            sof = sof_first && (i == 0);
            px = sof ? 0 : d_x;
            py = sof ? 0 : d_y;
            a_in_valid = 1'b1;
            a_in_sof   = sof;
            a_in_data  = ramp ? 8'((py * 32 + px) & 255) : 8'($urandom);
            got = 1'b0; t = 0;
            while (!got && t < 200) begin
                @(negedge clk); got = a_in_ready;
                @(posedge clk); #2; t++;
            end
            if (!got) begin
                checks++; failures++;
                $display("FAIL a_accept_timeout pixel=%0d got=no_accept required=accept", i);
                a_in_valid = 1'b0; a_in_sof = 1'b0;
                return;
            end
            d_x = px + 1; d_y = py;
            if (d_x == A_W) begin
                d_x = 0; d_y = py + 1;
                if (d_y == A_H) d_y = 0;
            end
        end
        a_in_valid = 1'b0;
        a_in_sof   = 1'b0;
    endtask

    task automatic drain();
        repeat (20) @(posedge clk);
        #2;
    endtask

    task automatic check_seq(input string name);
        int bad;
        bad = 0;
        checks++;
        if (a_rec.size() != ref_seq.size()) begin
            failures++;
            $display("FAIL %s_len got=%0d required=%0d", name, a_rec.size(), ref_seq.size());
        end else begin
            for (int i = 0; i < a_rec.size(); i++)
                if (a_rec[i] !== ref_seq[i]) bad++;
            if (bad != 0) begin
                failures++;
                $display("FAIL %s_seq got=%0d differing windows required=0", name, bad);
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        a_in_valid = 1'b0; a_in_sof = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_sof = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_out_x !== '0 || a_out_y !== '0 ||
            a_out_last !== 1'b0 || a_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_a got v=%b x=%0d y=%0d last=%b rdy=%b required all zero",
                     a_out_valid, a_out_x, a_out_y, a_out_last, a_in_ready);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_out_data !== '0 || b_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_b got v=%b rdy=%b required zero", b_out_valid, b_in_ready);
        end
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #2;
    endtask

    task automatic test_ramp();
        int bad;
        a_reset_stats(); d_x = 0; d_y = 0;
        drive_a(1024, 1'b1, 1'b1, 0);
        drain();
        checks++;
        if (a_got != 784) begin failures++; $display("FAIL ramp_count got=%0d required=784", a_got); end
        checks++;
        if (a_first_acc != 133) begin failures++; $display("FAIL ramp_latency got=%0d accepts required=133", a_first_acc); end
        checks++;
        if (a_lastcnt != 1) begin failures++; $display("FAIL ramp_last_count got=%0d required=1", a_lastcnt); end
        if (a_rec.size() == 784) begin
            checks++;
            if (a_rec[0][A_WIN+9:A_WIN] !== 10'd0 || a_rec[0][7:0] !== 8'h00 || a_rec[0][199:192] !== 8'h84) begin
                failures++;
                $display("FAIL ramp_first got yx=%h e00=%h e44=%h required yx=000 e00=00 e44=84",
                         a_rec[0][A_WIN+9:A_WIN], a_rec[0][7:0], a_rec[0][199:192]);
            end
            checks++;
            if (a_rec[783][A_WIN+9:A_WIN] !== {5'd27, 5'd27}) begin
                failures++;
                $display("FAIL ramp_final got yx=%h required y=27 x=27", a_rec[783][A_WIN+9:A_WIN]);
            end
            bad = 0;
            for (int i = 0; i < 784; i++) begin
                int ox, oy;
                ox = int'(a_rec[i][A_WIN+4:A_WIN]);
                oy = int'(a_rec[i][A_WIN+9:A_WIN+5]);
                for (int r = 0; r < A_K; r++)
                    for (int c = 0; c < A_K; c++)
                        if (a_rec[i][(r * A_K + c) * 8 +: 8] !== 8'(((oy + r) * 32 + ox + c) & 255)) bad++;
            end
            checks++;
            if (bad != 0) begin failures++; $display("FAIL ramp_elements got=%0d wrong elements required=0", bad); end
        end
        ref_seq = a_rec;
    endtask

    task automatic test_backpressure();
        a_reset_stats(); d_x = 0; d_y = 0;
        fork
            drive_a(1024, 1'b1, 1'b1, 0);
            begin
                logic [A_WIN-1:0] sd;
                logic [4:0] sx, sy;
                logic sv;
                repeat (400) @(posedge clk);
                #2 a_out_ready = 1'b0;
                @(negedge clk);
                sd = a_out_data; sx = a_out_x; sy = a_out_y; sv = a_out_valid;
                checks++;
                if (sv !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b required=1", sv); end
                for (int i = 0; i < 10; i++) begin
                    @(negedge clk);
                    checks++;
                    if (a_in_ready !== 1'b0 || a_out_valid !== sv || a_out_data !== sd ||
                        a_out_x !== sx || a_out_y !== sy) begin
                        failures++;
                        $display("FAIL bp_stable got rdy=%b x=%0d y=%0d required rdy=0 x=%0d y=%0d",
                                 a_in_ready, a_out_x, a_out_y, sx, sy);
                    end
                end
                @(posedge clk); #2 a_out_ready = 1'b1;
            end
        join
        drain();
        check_seq("bp");
    endtask

    task automatic test_gaps();
        a_reset_stats(); d_x = 0; d_y = 0;
        drive_a(1024, 1'b1, 1'b1, 50);
        drain();
        check_seq("gaps");
    endtask

    task automatic test_sof_restart();
        a_reset_stats(); d_x = 0; d_y = 0;
        drive_a(200, 1'b1, 1'b1, 0);
        a_acc = 0; a_first_acc = -1;
        drive_a(1024, 1'b1, 1'b1, 0);
        drain();
        checks++;
        if (a_first_acc != 133 || a_first_x != 0 || a_first_y != 0) begin
            failures++;
            $display("FAIL sof_restart got acc=%0d x=%0d y=%0d required acc=133 x=0 y=0",
                     a_first_acc, a_first_x, a_first_y);
        end
        checks++;
        if (a_lastcnt != 1) begin failures++; $display("FAIL sof_last got=%0d required=1", a_lastcnt); end
    endtask

    task automatic test_random();
        bit done;
        done = 1'b0;
        a_reset_stats(); d_x = 0; d_y = 0;
        fork
            begin drive_a(1024, 1'b1, 1'b0, 30); done = 1'b1; end
            begin
                while (!done) begin
                    @(posedge clk); #2 a_out_ready = 1'($urandom_range(1));
                end
                a_out_ready = 1'b1;
            end
        join
        drain();
        checks++;
        if (a_got != 784 || a_lastcnt != 1) begin
            failures++;
            $display("FAIL random_count got=%0d last=%0d required 784 and 1", a_got, a_lastcnt);
        end
    endtask

    task automatic test_reset_midframe();
        logic pre_v;
        a_reset_stats(); d_x = 0; d_y = 0;
        drive_a(500, 1'b1, 1'b1, 0);
        pre_v = a_out_valid;
        rst = 1'b1;
        #1;
        checks++;
        if (pre_v !== 1'b1) begin failures++; $display("FAIL rstmid_pre_valid got=%b required=1", pre_v); end
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== '0 || a_out_x !== '0 || a_out_y !== '0 ||
            a_out_last !== 1'b0 || a_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_clear got v=%b x=%0d y=%0d rdy=%b required zero",
                     a_out_valid, a_out_x, a_out_y, a_in_ready);
        end
        @(posedge clk); @(posedge clk); #2;
        rst = 1'b0;
        a_reset_stats(); d_x = 0; d_y = 0;
        drive_a(1024, 1'b0, 1'b1, 0);
        drain();
        check_seq("rstmid");
    endtask

    task automatic test_two_frames();
        int bad;
        b_got = 0; b_lastpos.delete(); b_rec.delete();
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < B_W * B_H; i++) begin
                logic [7:0] v;
                int t;
                bit got;
                v = 8'($urandom);
                b_in_valid = 1'b1; b_in_sof = (i == 0); b_in_data = {~v, v};
                got = 1'b0; t = 0;
                while (!got && t < 200) begin
                    @(negedge clk); got = b_in_ready;
                    @(posedge clk); #2; t++;
                end
                if (!got) begin
                    checks++; failures++;
                    $display("FAIL b_accept_timeout got=no_accept required=accept");
                    break;
                end
            end
        end
        b_in_valid = 1'b0; b_in_sof = 1'b0;
        drain();
        checks++;
        if (b_got != 72) begin failures++; $display("FAIL two_frames_count got=%0d required=72", b_got); end
        checks++;
        if (b_lastpos.size() != 2 || b_lastpos[0] != 36 || b_lastpos[1] != 72) begin
            failures++;
            $display("FAIL two_frames_last got n=%0d required last at 36 and 72", b_lastpos.size());
        end
        bad = 0;
        foreach (b_rec[i])
            for (int e = 0; e < B_K * B_K; e++)
                if (b_rec[i][e * 16 + 8 +: 8] !== ~b_rec[i][e * 16 +: 8]) bad++;
        checks++;
        if (bad != 0) begin failures++; $display("FAIL two_frames_ch1 got=%0d bad elements required=0", bad); end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_backpressure();
        test_gaps();
        test_sof_restart();
        test_random();
        test_reset_midframe();
        test_two_frames();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
